icache_fetch_controller: RTL and testbench



---
 rtl/icache_fetch_controller.sv | 175 +++++++++++++++++
 tb/tb_icache_fetch_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_controller.sv
// Fetch-side sequencer for the 2-way instruction cache: one PC at a time,
// lookup, miss fill from instruction memory, flush/timeout handling and stats.
module icache_fetch_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic [31:0]           core_pc,
  output logic                  core_resp_valid,
  input  logic                  core_resp_ready,
  output logic [31:0]           core_resp_instr,
  output logic                  core_resp_error,
  input  logic                  flush,
  output logic [9:0]            cache_address,
  output logic                  cache_update_enable,
  output logic [31:0]           cache_im_data,
  input  logic                  cache_hit,
  input  logic [31:0]           cache_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the source keeps valid and payload unchanged until that edge.
  typedef enum logic [2:0] {
    IDLE, LOOKUP, HIT_DATA, MEM_REQ, MEM_WAIT, FILL, RESP
  } state_t;

  state_t                  state, state_next;
  logic [31:2]             pc_q, pc_next;
  logic [31:0]             instr_q, instr_next;
  logic                    error_q, error_next;
  logic                    drop_q, drop_next;
  logic [7:0]              tcnt_q, tcnt_next;
  logic [STAT_WIDTH-1:0]   hits_q, hits_next;
  logic [STAT_WIDTH-1:0]   misses_q, misses_next;
  logic                    timed_out;

  assign timed_out = (tcnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      error_q  <= 1'b0;
      drop_q   <= 1'b0;
      tcnt_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state    <= state_next;
      pc_q     <= pc_next;
      instr_q  <= instr_next;
      error_q  <= error_next;
      drop_q   <= drop_next;
      tcnt_q   <= tcnt_next;
      hits_q   <= hits_next;
      misses_q <= misses_next;
    end
  end

  always_comb begin
    state_next          = state;
    pc_next             = pc_q;
    instr_next          = instr_q;
    error_next          = error_q;
    drop_next           = drop_q;
    tcnt_next           = tcnt_q;
    hits_next           = hits_q;
    misses_next         = misses_q;
    core_req_ready      = 1'b0;
    core_resp_valid     = 1'b0;
    mem_req_valid       = 1'b0;
    cache_update_enable = 1'b0;
    case (state)
      IDLE: begin
        core_req_ready = 1'b1;
        if (core_req_valid && !flush) begin
          pc_next = core_pc[31:2];
          if (core_pc[1:0] != 2'b00) begin
            state_next = RESP;
            error_next = 1'b1;
            instr_next = '0;
          end else begin
            state_next = LOOKUP;
            error_next = 1'b0;
          end
        end
      end
      LOOKUP: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cache_hit) begin
          hits_next  = (&hits_q) ? hits_q : hits_q + STAT_WIDTH'(1);
          state_next = HIT_DATA;
        end else begin
          misses_next = (&misses_q) ? misses_q : misses_q + STAT_WIDTH'(1);
          tcnt_next   = '0;
          state_next  = MEM_REQ;
        end
      end
      HIT_DATA: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          instr_next = cache_data;
          error_next = 1'b0;
          state_next = RESP;
        end
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        tcnt_next     = tcnt_q + 8'd1;
        if (flush) drop_next = 1'b1;
        if (mem_req_ready) begin
          state_next = MEM_WAIT;
        end else if (timed_out) begin
          if (drop_next) begin
            state_next = IDLE;
          end else begin
            state_next = RESP;
            error_next = 1'b1;
            instr_next = '0;
          end
        end
      end
      MEM_WAIT: begin
        tcnt_next = tcnt_q + 8'd1;
        if (flush) drop_next = 1'b1;
        if (mem_resp_valid) begin
          instr_next = mem_resp_data;
          state_next = FILL;
        end else if (timed_out) begin
          if (drop_next) begin
            state_next = IDLE;
          end else begin
            state_next = RESP;
            error_next = 1'b1;
            instr_next = '0;
          end
        end
      end
      FILL: begin
        // The filled word itself is the response; no second lookup.
        cache_update_enable = 1'b1;
        error_next          = 1'b0;
        state_next          = (drop_q || flush) ? IDLE : RESP;
      end
      RESP: begin
        core_resp_valid = 1'b1;
        if (core_resp_ready || flush) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE) drop_next = 1'b0;
  end

  assign core_resp_instr = instr_q;
  assign core_resp_error = error_q;
  assign cache_address   = pc_q[11:2];
  assign cache_im_data   = instr_q;
  assign mem_req_addr    = {pc_q, 2'b00};
  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;

endmodule

// File: tb/tb_icache_fetch_controller.sv
// Bench for icache_fetch_controller: behavioural cache and memory around the
// DUT, a reference model of fetch results and a queue-based response monitor.
module tb_icache_fetch_controller;
  localparam int SW   = 4;
  localparam int TMO  = 255;
  localparam int MAXS = (1 << SW) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic core_req_valid = 1'b0, core_req_ready, core_resp_valid, core_resp_ready = 1'b0;
  logic [31:0] core_pc = '0, core_resp_instr;
  logic core_resp_error, flush = 1'b0;
  logic [9:0] cache_address;
  logic cache_update_enable, cache_hit;
  logic [31:0] cache_im_data, cache_data;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_req_addr, mem_resp_data = '0;
  logic [SW-1:0] stat_hits, stat_misses;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, rise_cyc = 0;
  int ref_hits = 0, ref_misses = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mreq_q[$];
  logic [41:0] fill_q[$];
  logic [31:0] ref_line[int];

  icache_fetch_controller #(.TIMEOUT_CYCLES(TMO), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_pc(core_pc),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_instr(core_resp_instr), .core_resp_error(core_resp_error), .flush(flush),
    .cache_address(cache_address), .cache_update_enable(cache_update_enable),
    .cache_im_data(cache_im_data), .cache_hit(cache_hit), .cache_data(cache_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // cache: combinational hit by word index, registered read data
  logic [1023:0] cv;
  logic [31:0]   cd[1024];
  assign cache_hit = cv[cache_address];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cv <= '0;
      cache_data <= '0;
    end else begin
      cache_data <= cd[cache_address];
      if (cache_update_enable) begin
        cv[cache_address] <= 1'b1;
        cd[cache_address] <= cache_im_data;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, required none", name);
  endtask

  // monitor / scoreboard
  logic pv = 0, pr = 0, pf = 0, pe = 0, pmv = 0, pmr = 0;
  logic [31:0] pi = '0, pma = '0;
  always @(negedge clk) begin
    logic [32:0] e;
    logic [41:0] f;
    if (reset) begin
      pv <= 1'b0;
      pmv <= 1'b0;
    end else begin
      if (core_resp_valid && !pv) rise_cyc <= cyc;
      if (pv && !pr && !pf) begin
        check("resp_hold_valid", 32'(core_resp_valid), 32'd1);
        check("resp_hold_instr", core_resp_instr, pi);
        check("resp_hold_error", 32'(core_resp_error), 32'(pe));
      end
      if (core_resp_valid && !flush && exp_q.size() == 0) flag("unexpected_resp");
      if (core_resp_valid && core_resp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_instr", core_resp_instr, e[31:0]);
        check("resp_error", 32'(core_resp_error), 32'(e[32]));
      end
      pv <= core_resp_valid; pr <= core_resp_ready; pf <= flush;
      pi <= core_resp_instr; pe <= core_resp_error;

      if (pmv && !pmr) begin
        check("mreq_hold_valid", 32'(mem_req_valid), 32'd1);
        check("mreq_hold_addr", mem_req_addr, pma);
      end
      if (mem_req_valid && mreq_q.size() == 0) flag("unexpected_mem_req");
      if (mem_req_valid && mem_req_ready && mreq_q.size() != 0)
        check("mreq_addr", mem_req_addr, mreq_q.pop_front());
      pmv <= mem_req_valid; pmr <= mem_req_ready; pma <= mem_req_addr;

      if (cache_update_enable) begin
        if (fill_q.size() == 0) flag("unexpected_fill");
        else begin
          f = fill_q.pop_front();
          check("fill_addr", 32'(cache_address), 32'(f[41:32]));
          check("fill_data", cache_im_data, f[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int sat(input int v);
    return (v > MAXS) ? MAXS : v;
  endfunction

  task automatic check_stats();
    check("stat_hits", 32'(stat_hits), ref_hits);
    check("stat_misses", 32'(stat_misses), ref_misses);
  endtask

  task automatic accept(input logic [31:0] pc);
    core_req_valid = 1'b1;
    core_pc = pc;
    check("req_ready", 32'(core_req_ready), 32'd1);
    tick();
    core_req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_mreq();
    int n = 0;
    while (!mem_req_valid && n < 20) begin tick(); n++; end
    check("mem_req_seen", 32'(mem_req_valid), 32'd1);
  endtask

  task automatic serve_mem(input int lo, input int dly, input logic [31:0] d, input bit mute);
    wait_mreq();
    tick(lo);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    if (!mute) begin
      tick(dly);
      mem_resp_valid = 1'b1; mem_resp_data = d; tick(); mem_resp_valid = 1'b0;
    end
  endtask

  task automatic take_resp(input int hold);
    int n = 0;
    while (!core_resp_valid && n < 400) begin tick(); n++; end
    check("resp_arrives", 32'(core_resp_valid), 32'd1);
    if (!core_resp_valid) return;
    tick(hold);
    core_resp_ready = 1'b1; tick(); core_resp_ready = 1'b0;
  endtask

  // reference model: word index -> cached word; memory answers with d
  task automatic fetch(input logic [31:0] pc, input int lo, input int dly, input int hold,
                       input logic [31:0] d, input bit mute);
    int idx;
    bit miss;
    idx = int'(pc[11:2]);
    miss = 1'b0;
    if (pc[1:0] != 2'b00) exp_q.push_back({1'b1, 32'h0});
    else if (ref_line.exists(idx)) begin
      exp_q.push_back({1'b0, ref_line[idx]});
      ref_hits = sat(ref_hits + 1);
    end else begin
      miss = 1'b1;
      ref_misses = sat(ref_misses + 1);
      mreq_q.push_back({pc[31:2], 2'b00});
      if (mute) exp_q.push_back({1'b1, 32'h0});
      else begin
        exp_q.push_back({1'b0, d});
        fill_q.push_back({pc[11:2], d});
        ref_line[idx] = d;
      end
    end
    accept(pc);
    if (miss) serve_mem(lo, dly, d, mute);
    take_resp(hold);
    check_stats();
  endtask

  initial begin
    logic [31:0] pc;
    tick(3);
    check("rst_req_ready", 32'(core_req_ready), 32'd1);
    check("rst_resp_valid", 32'(core_resp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_fill", 32'(cache_update_enable), 32'd0);
    check("rst_instr", core_resp_instr, 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    check_stats();
    reset = 1'b0;
    tick();

    fetch(32'h0000_0040, 0, 0, 0, 32'h0010_0093, 1'b0);
    check("miss_latency", rise_cyc - acc_cyc, 32'd4);
    fetch(32'h0000_0040, 0, 0, 0, 32'h0, 1'b0);
    check("hit_latency", rise_cyc - acc_cyc, 32'd2);
    fetch(32'h0000_0100, 5, 1, 3, 32'h1234_5678, 1'b0);
    fetch(32'h0000_0042, 0, 0, 0, 32'h0, 1'b0);

    fetch(32'h0000_0200, 0, 0, 0, 32'h0, 1'b1);
    check("timeout_latency", 32'((rise_cyc - acc_cyc >= TMO) && (rise_cyc - acc_cyc <= TMO + 4)), 32'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0; tick(); mem_resp_valid = 1'b0;
    tick();
    check("late_resp_idle", 32'(core_req_ready), 32'd1);
    fetch(32'h0000_0200, 1, 2, 1, 32'h0200_0013, 1'b0);

    // flush while waiting for memory: fill still lands, no response
    ref_misses = sat(ref_misses + 1);
    mreq_q.push_back(32'h0000_0080);
    fill_q.push_back({10'h020, 32'hDEAD_BEEF});
    ref_line[32'h20] = 32'hDEAD_BEEF;
    accept(32'h0000_0080);
    wait_mreq();
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; tick(); mem_resp_valid = 1'b0;
    tick(3);
    check("flush_wait_idle", 32'(core_req_ready), 32'd1);
    check_stats();
    fetch(32'h0000_0080, 0, 0, 0, 32'h0, 1'b0);

    // flush while the request is still being offered
    ref_misses = sat(ref_misses + 1);
    mreq_q.push_back(32'h0000_0500);
    fill_q.push_back({10'h140, 32'hCAFE_0001});
    ref_line[32'h140] = 32'hCAFE_0001;
    accept(32'h0000_0500);
    wait_mreq();
    flush = 1'b1; tick(); flush = 1'b0;
    tick(2);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_0001; tick(); mem_resp_valid = 1'b0;
    tick(3);
    check("flush_req_idle", 32'(core_req_ready), 32'd1);

    // flush in HIT_DATA: hit stays counted
    ref_hits = sat(ref_hits + 1);
    accept(32'h0000_0080);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    check("flush_hit_idle", 32'(core_req_ready), 32'd1);
    check_stats();

    // flush while a response is pending
    accept(32'h0000_0306);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_resp_dropped", 32'(core_resp_valid), 32'd0);
    check("flush_resp_idle", 32'(core_req_ready), 32'd1);

    // request together with flush is not accepted
    core_req_valid = 1'b1; core_pc = 32'h0000_0080; flush = 1'b1;
    tick();
    core_req_valid = 1'b0; flush = 1'b0;
    check("flush_block_idle", 32'(core_req_ready), 32'd1);
    tick(2);
    check("flush_block_noresp", 32'(core_resp_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      pc = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      fetch(pc, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), $urandom, 1'b0);
    end

    // reset in MEM_WAIT abandons everything
    mreq_q.push_back(32'h0000_0C00);
    accept(32'h0000_0C00);
    wait_mreq();
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    tick(2);
    reset = 1'b1;
    #1;
    exp_q.delete(); mreq_q.delete(); fill_q.delete(); ref_line.delete();
    ref_hits = 0; ref_misses = 0;
    check("mid_reset_ready", 32'(core_req_ready), 32'd1);
    check("mid_reset_mreq", 32'(mem_req_valid), 32'd0);
    check_stats();
    tick();
    reset = 1'b0;
    tick();

    fetch(32'h0000_0040, 0, 0, 0, 32'h0000_0013, 1'b0);
    repeat (MAXS + 2) fetch(32'h0000_0040, 0, 0, 0, 32'h0, 1'b0);
    check("stat_hits_saturated", 32'(stat_hits), MAXS);

    tick(3);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("mreq_q_drained", mreq_q.size(), 32'd0);
    check("fill_q_drained", fill_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
